// File: rtl/sudoku_pkg.sv
// Shared constants and types for the sudoku accelerator Wishbone front end.
package sudoku_pkg;

    localparam int NUM_CELLS  = 81;
    localparam int CELL_W     = 4;
    localparam int IDX_W      = 7;
    localparam int WORD_IDX_W = 4;

    localparam logic [IDX_W-1:0]      LAST_IDX         = IDX_W'(NUM_CELLS - 1);
    localparam logic [WORD_IDX_W-1:0] PUZZLE_LAST_WORD = 4'd10;
    // Word index that matches no cell, used when the bus is not addressing the puzzle.
    localparam logic [WORD_IDX_W-1:0] NO_WORD          = 4'hF;

    // Register offsets inside the 256-byte window.
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_IRQ_EN = 8'h08;
    localparam logic [7:0] OFF_PUZZLE = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

endpackage

// File: rtl/sudoku_cell_store.sv
// 81-cell puzzle buffer: bus and solver write ports (solver wins on the same
// cell), a streaming read port and a 32-bit word read port for the bus.
module sudoku_cell_store
    import sudoku_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  bus_we_i,
    input  logic [WORD_IDX_W-1:0] bus_word_i,
    input  logic [3:0]            bus_sel_i,
    input  logic [31:0]           bus_dat_i,
    output logic [31:0]           bus_dat_o,
    input  logic                  res_we_i,
    input  logic [IDX_W-1:0]      res_idx_i,
    input  logic [CELL_W-1:0]     res_val_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [CELL_W-1:0]     rd_val_o
);

    logic [CELL_W-1:0] cells_q [NUM_CELLS];

    // Per-cell write: solver write-back first, then byte-gated bus write.
    // NOTE: this array is deliberately reset -- a reset mid-solve must clear the puzzle,
    // so it is built from flops rather than a RAM macro.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CELLS; c++) begin
                // NOTE: non-blocking assignment for every sequential update, so all
                // cells see pre-edge values regardless of statement order.
                cells_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CELLS; c++) begin
                if (res_we_i && res_idx_i == IDX_W'(c)) begin
                    cells_q[c] <= res_val_i;
                end else if (bus_we_i && bus_word_i == WORD_IDX_W'(c / 8) && bus_sel_i[(c % 8) / 2]) begin
                    cells_q[c] <= bus_dat_i[4 * (c % 8) +: 4];
                end
            end
        end
    end

    // Assemble the addressed bus word; cells past 80 and unmatched words read 0.
    always_comb begin
        // NOTE: defaults first so no path through the loop leaves a bit unassigned (no latch).
        bus_dat_o = '0;
        for (int c = 0; c < NUM_CELLS; c++) begin
            if (bus_word_i == WORD_IDX_W'(c / 8)) begin
                bus_dat_o[4 * (c % 8) +: 4] = cells_q[c];
            end
        end
    end

    // Streaming read port, a plain mux over the cells.
    always_comb begin
        rd_val_o = '0;
        for (int c = 0; c < NUM_CELLS; c++) begin
            if (rd_idx_i == IDX_W'(c)) begin
                rd_val_o = cells_q[c];
            end
        end
    end

endmodule

// File: rtl/sudoku_wb_loader.sv
// Wishbone front end of the sudoku accelerator: register decode, ack,
// streaming state machine, status and interrupt.
module sudoku_wb_loader
    import sudoku_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic              wb_ack_o,
    output logic [31:0]       wb_dat_o,
    output logic              cell_valid_o,
    input  logic              cell_ready_i,
    output logic [IDX_W-1:0]  cell_idx_o,
    output logic [CELL_W-1:0] cell_val_o,
    input  logic              res_valid_i,
    input  logic [IDX_W-1:0]  res_idx_i,
    input  logic [CELL_W-1:0] res_val_i,
    input  logic              solver_done_i,
    input  logic              solver_fail_i,
    output logic              irq_o
);

    logic [7:0]            offset;
    logic                  req;
    logic                  commit_wr;
    logic                  puzzle_hit;
    logic [WORD_IDX_W-1:0] word_idx;
    logic [31:0]           puzzle_rd;
    logic [31:0]           rdata;
    logic                  ack_q, ack_d;
    logic [31:0]           dat_q, dat_d;

    state_e                state_q;
    logic                  valid_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  done_q, fail_q, irq_en_q;

    logic                  ctrl_wr, status_wr, irq_en_wr, puzzle_wr;
    logic                  start_cmd, abort_cmd, done_set, done_clr;
    logic                  handshake;

    assign offset     = wb_adr_i[7:0];
    assign req        = wb_cyc_i & wb_stb_i & (wb_adr_i[31:8] == BASE_ADDR[31:8]);
    // Writes take effect at the end of the ack cycle, while the master still holds the request.
    assign commit_wr  = ack_q & req & wb_we_i;

    assign puzzle_hit = (offset[7:6] == OFF_PUZZLE[7:6]) && (offset[1:0] == 2'b00)
                        && (offset[5:2] <= PUZZLE_LAST_WORD);
    assign word_idx   = puzzle_hit ? offset[5:2] : NO_WORD;

    assign ctrl_wr    = commit_wr && (offset == OFF_CTRL)   && wb_sel_i[0];
    assign status_wr  = commit_wr && (offset == OFF_STATUS) && wb_sel_i[0];
    assign irq_en_wr  = commit_wr && (offset == OFF_IRQ_EN) && wb_sel_i[0];
    // The puzzle is locked while the solver owns it.
    assign puzzle_wr  = commit_wr && puzzle_hit && (state_q == ST_IDLE);

    assign start_cmd  = ctrl_wr & wb_dat_i[0];
    assign abort_cmd  = ctrl_wr & wb_dat_i[1];
    assign done_set   = (state_q == ST_WAIT) & solver_done_i & ~abort_cmd;
    assign done_clr   = status_wr & wb_dat_i[2];
    assign handshake  = valid_q & cell_ready_i;

    sudoku_cell_store u_store (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .bus_we_i   (puzzle_wr),
        .bus_word_i (word_idx),
        .bus_sel_i  (wb_sel_i),
        .bus_dat_i  (wb_dat_i),
        .bus_dat_o  (puzzle_rd),
        .res_we_i   (res_valid_i),
        .res_idx_i  (res_idx_i),
        .res_val_i  (res_val_i),
        .rd_idx_i   (idx_q),
        .rd_val_o   (cell_val_o)
    );

    // Read data mux for the addressed register.
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_STATUS: rdata[3:0] = {fail_q, done_q, state_q};
            OFF_IRQ_EN: rdata[0]   = irq_en_q;
            default:    if (puzzle_hit) rdata = puzzle_rd;
        endcase
    end

    // One ack per sampled request; read data lives only during the ack cycle.
    assign ack_d = req & ~ack_q;
    assign dat_d = (req && !ack_q && !wb_we_i) ? rdata : '0;

    // Wishbone ack and read-data registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    // Streaming state machine: IDLE -> STREAM -> WAIT -> IDLE, ABORT from anywhere.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else if (abort_cmd) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_cmd) begin
                        state_q <= ST_STREAM;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                ST_STREAM: begin
                    if (handshake) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_WAIT;
                            valid_q <= 1'b0;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (solver_done_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    // Sticky DONE/FAIL; a completion in the same cycle as a clear wins.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (done_set) begin
            done_q <= 1'b1;
            fail_q <= solver_fail_i;
        end else if (done_clr) begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
        end
    end

    // Interrupt enable register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_en_q <= 1'b0;
        end else if (irq_en_wr) begin
            irq_en_q <= wb_dat_i[0];
        end
    end

    assign wb_ack_o     = ack_q;
    assign wb_dat_o     = dat_q;
    assign cell_valid_o = valid_q;
    assign cell_idx_o   = idx_q;
    assign irq_o        = done_q & irq_en_q;

endmodule

// File: tb/tb_sudoku_wb_loader.sv
// Self-checking bench for sudoku_wb_loader: register access, streaming with
// backpressure, completion/interrupt, abort and lockout, write contention, reset.
module tb_sudoku_wb_loader;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_IRQE = BASE + 32'h08;
    localparam logic [31:0] A_PUZ  = BASE + 32'h40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        cell_valid;
    logic        cell_ready = 1'b0;
    logic [6:0]  cell_idx;
    logic [3:0]  cell_val;
    logic        res_valid = 1'b0;
    logic [6:0]  res_idx = '0;
    logic [3:0]  res_val = '0;
    logic        solver_done = 1'b0, solver_fail = 1'b0;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [3:0] model [81];

    typedef struct {
        int         idx;
        logic [3:0] val;
    } cell_exp_t;
    cell_exp_t exp_q [$];

    always #5 clk = ~clk;

    sudoku_wb_loader #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wb_cyc_i      (cyc),
        .wb_stb_i      (stb),
        .wb_we_i       (we),
        .wb_sel_i      (sel),
        .wb_adr_i      (adr),
        .wb_dat_i      (wdat),
        .wb_ack_o      (ack),
        .wb_dat_o      (rdat),
        .cell_valid_o  (cell_valid),
        .cell_ready_i  (cell_ready),
        .cell_idx_o    (cell_idx),
        .cell_val_o    (cell_val),
        .res_valid_i   (res_valid),
        .res_idx_i     (res_idx),
        .res_val_i     (res_val),
        .solver_done_i (solver_done),
        .solver_fail_i (solver_fail),
        .irq_o         (irq)
    );

    function automatic logic [31:0] model_word(input int k);
        logic [31:0] w = '0;
        for (int j = 0; j < 8; j++) begin
            if (8 * k + j < 81) w[4 * j +: 4] = model[8 * k + j];
        end
        return w;
    endfunction

    task automatic model_write(input int k, input logic [31:0] d, input logic [3:0] s);
        for (int j = 0; j < 8; j++) begin
            if (8 * k + j < 81 && s[j / 2]) model[8 * k + j] = d[4 * j +: 4];
        end
    endtask

    // One classic Wishbone transfer; returns read data and cycles from request to ack.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output int lat);
        r   = '0;
        lat = 0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 8);
        if (!ack) begin
            total++; bad++;
            $display("FAIL wb_ack_timeout addr=%h got=no_ack want=ack", a);
        end else begin
            r = rdat;
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int lat);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, s, dummy, lat);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] r, output int lat);
        wb_xfer(1'b0, a, '0, 4'hF, r, lat);
    endtask

    task automatic pulse_done(input logic fail);
        @(posedge clk); #1;
        solver_done = 1'b1; solver_fail = fail;
        @(posedge clk); #1;
        solver_done = 1'b0; solver_fail = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        int lat;
        for (int c = 0; c < 81; c++) model[c] = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (irq !== 1'b0 || cell_valid !== 1'b0 || ack !== 1'b0 || rdat !== 32'h0 || cell_idx !== 7'd0 || cell_val !== 4'd0) begin
            bad++;
            $display("FAIL reset_outputs got=irq%b valid%b ack%b dat%h idx%0d val%0d want=all_zero",
                     irq, cell_valid, ack, rdat, cell_idx, cell_val);
        end
        rst = 1'b0;
        for (int k = 0; k < 11; k++) begin
            wb_read(A_PUZ + 32'(4 * k), r, lat);
            total++;
            if (r !== 32'h0) begin bad++; $display("FAIL reset_puzzle_word%0d got=%h want=0", k, r); end
        end
        wb_read(A_STAT, r, lat);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL reset_status got=%h want=0", r); end
        wb_write(A_IRQE, 32'h1, 4'hF, lat);
        wb_read(A_IRQE, r, lat);
        total++;
        if (r !== 32'h1) begin bad++; $display("FAIL irq_en_readback got=%h want=1", r); end
    endtask

    task automatic test_round_trip;
        logic [31:0] r;
        int lat;
        bit miss_ack;
        wb_write(A_PUZ, 32'h8765_4321, 4'hF, lat);
        model_write(0, 32'h8765_4321, 4'hF);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL write_ack_latency got=%0d want=1", lat); end
        wb_write(A_PUZ + 32'h8, 32'h4, 4'b0001, lat);
        model_write(2, 32'h4, 4'b0001);
        wb_read(A_PUZ, r, lat);
        total++;
        if (r !== 32'h8765_4321) begin bad++; $display("FAIL round_trip_w0 got=%h want=87654321", r); end
        total++;
        if (lat !== 1) begin bad++; $display("FAIL read_ack_latency got=%0d want=1", lat); end
        wb_read(A_PUZ + 32'h8, r, lat);
        total++;
        if (r !== 32'h0000_0004) begin bad++; $display("FAIL round_trip_w2 got=%h want=00000004", r); end
        wb_write(A_PUZ + 32'h8, 32'hAAAA_AAAA, 4'b0100, lat);
        model_write(2, 32'hAAAA_AAAA, 4'b0100);
        wb_read(A_PUZ + 32'h8, r, lat);
        total++;
        if (r !== model_word(2)) begin bad++; $display("FAIL byte_lane_w2 got=%h want=%h", r, model_word(2)); end
        wb_write(A_PUZ + 32'h28, 32'hFFFF_FFFF, 4'hF, lat);
        model_write(10, 32'hFFFF_FFFF, 4'hF);
        wb_read(A_PUZ + 32'h28, r, lat);
        total++;
        if (r !== 32'h0000_000F) begin bad++; $display("FAIL word10_upper got=%h want=0000000f", r); end
        wb_read(BASE + 32'h0C, r, lat);
        total++;
        if (r !== 32'h0 || lat !== 1) begin bad++; $display("FAIL unmapped_read got=%h lat%0d want=0 lat1", r, lat); end
        // Address outside the window must never be acked.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h100; sel = 4'hF;
        miss_ack = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack) miss_ack = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0;
        total++;
        if (miss_ack !== 1'b0) begin bad++; $display("FAIL addr_miss got=ack want=no_ack"); end
    endtask

    task automatic test_stream;
        logic [31:0] r, d;
        int lat, seen;
        bit fell;
        cell_exp_t e;
        for (int k = 0; k < 11; k++) begin
            d = '0;
            for (int j = 0; j < 8; j++) begin
                if (8 * k + j < 81) d[4 * j +: 4] = 4'((8 * k + j) % 10);
            end
            wb_write(A_PUZ + 32'(4 * k), d, 4'hF, lat);
            model_write(k, d, 4'hF);
        end
        for (int i = 0; i < 81; i++) exp_q.push_back('{i, model[i]});
        wb_write(A_CTRL, 32'h1, 4'h1, lat);
        total++;
        if (cell_valid !== 1'b1 || cell_idx !== 7'd0) begin
            bad++; $display("FAIL start_first_cell got=valid%b idx%0d want=valid1 idx0", cell_valid, cell_idx);
        end
        wb_read(A_STAT, r, lat);
        total++;
        if (r !== 32'h1 || cell_idx !== 7'd0) begin
            bad++; $display("FAIL stream_state_hold got=%h idx%0d want=1 idx0", r, cell_idx);
        end
        seen = 0;
        fell = 1'b0;
        for (int cy = 0; cy < 400; cy++) begin
            @(posedge clk); #1;
            if (seen == 81) begin
                fell = !cell_valid;
                break;
            end
            cell_ready = ~cell_ready;
            if (cell_valid && cell_ready) begin
                e = exp_q.pop_front();
                total++;
                if (cell_idx !== 7'(e.idx) || cell_val !== e.val) begin
                    bad++; $display("FAIL stream_cell got=idx%0d val%0d want=idx%0d val%0d", cell_idx, cell_val, e.idx, e.val);
                end
                seen++;
            end
        end
        cell_ready = 1'b0;
        total++;
        if (seen !== 81 || exp_q.size() !== 0) begin bad++; $display("FAIL stream_count got=%0d want=81", seen); end
        total++;
        if (fell !== 1'b1) begin bad++; $display("FAIL valid_fall got=valid_high want=valid_low"); end
        wb_read(A_STAT, r, lat);
        total++;
        if (r !== 32'h2) begin bad++; $display("FAIL state_wait got=%h want=2", r); end
    endtask

    task automatic test_completion;
        logic [31:0] r;
        int lat;
        wb_write(A_IRQE, 32'h1, 4'hF, lat);
        @(posedge clk); #1;
        res_valid = 1'b1; res_idx = 7'd5; res_val = 4'd9;
        @(posedge clk); #1;
        res_valid = 1'b0;
        model[5] = 4'd9;
        pulse_done(1'b0);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_raise got=%b want=1", irq); end
        wb_read(A_STAT, r, lat);
        total++;
        if (r !== 32'h4) begin bad++; $display("FAIL status_done got=%h want=4", r); end
        wb_read(A_PUZ, r, lat);
        total++;
        if (r !== model_word(0)) begin bad++; $display("FAIL writeback_cell5 got=%h want=%h", r, model_word(0)); end
        wb_write(A_STAT, 32'h4, 4'h1, lat);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b want=0", irq); end
        pulse_done(1'b1);
        wb_read(A_STAT, r, lat);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL done_outside_wait got=%h want=0", r); end
    endtask

    task automatic test_abort_lockout;
        logic [31:0] r;
        int lat;
        bit reached;
        wb_write(A_CTRL, 32'h1, 4'h1, lat);
        cell_ready = 1'b1;
        reached = 1'b0;
        for (int cy = 0; cy < 200; cy++) begin
            @(posedge clk); #1;
            if (cell_valid && cell_idx == 7'd40) begin
                cell_ready = 1'b0;
                reached = 1'b1;
                break;
            end
        end
        cell_ready = 1'b0;
        total++;
        if (!reached) begin bad++; $display("FAIL reach_cell40 got=idx%0d want=idx40", cell_idx); end
        wb_write(A_PUZ, 32'hFFFF_FFFF, 4'hF, lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL locked_write_ack got=%0d want=1", lat); end
        wb_read(A_PUZ, r, lat);
        total++;
        if (r !== model_word(0)) begin bad++; $display("FAIL locked_write got=%h want=%h", r, model_word(0)); end
        wb_write(A_CTRL, 32'h1, 4'h1, lat);
        total++;
        if (cell_valid !== 1'b1 || cell_idx !== 7'd40) begin
            bad++; $display("FAIL restart_ignored got=valid%b idx%0d want=valid1 idx40", cell_valid, cell_idx);
        end
        wb_write(A_CTRL, 32'h2, 4'h1, lat);
        total++;
        if (cell_valid !== 1'b0 || cell_idx !== 7'd0) begin
            bad++; $display("FAIL abort got=valid%b idx%0d want=valid0 idx0", cell_valid, cell_idx);
        end
        wb_read(A_STAT, r, lat);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL abort_status got=%h want=0", r); end
    endtask

    task automatic test_contention;
        logic [31:0] r;
        int lat;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_PUZ; wdat = 32'h0000_000A; sel = 4'hF;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ack && lat < 8);
        // The bus write commits at the next edge; the solver writes cell 0 on that same edge.
        res_valid = 1'b1; res_idx = 7'd0; res_val = 4'd3;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
        res_valid = 1'b0;
        model_write(0, 32'h0000_000A, 4'hF);
        model[0] = 4'd3;
        wb_read(A_PUZ, r, lat);
        total++;
        if (r !== model_word(0)) begin bad++; $display("FAIL contention got=%h want=%h", r, model_word(0)); end
    endtask

    task automatic test_fail_and_reset;
        logic [31:0] r;
        int lat;
        bit fell;
        wb_write(A_CTRL, 32'h1, 4'h1, lat);
        cell_ready = 1'b1;
        fell = 1'b0;
        for (int cy = 0; cy < 200; cy++) begin
            @(posedge clk); #1;
            if (!cell_valid) begin
                fell = 1'b1;
                break;
            end
        end
        cell_ready = 1'b0;
        total++;
        if (!fell) begin bad++; $display("FAIL full_speed_stream got=valid_high want=valid_low"); end
        pulse_done(1'b1);
        wb_read(A_STAT, r, lat);
        total++;
        if (r !== 32'hC || irq !== 1'b1) begin bad++; $display("FAIL status_fail got=%h irq%b want=c irq1", r, irq); end
        wb_write(A_STAT, 32'h4, 4'h1, lat);
        wb_read(A_STAT, r, lat);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL fail_clear got=%h want=0", r); end
        wb_write(A_CTRL, 32'h1, 4'h1, lat);
        cell_ready = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (cell_valid !== 1'b0 || cell_idx !== 7'd0 || cell_val !== 4'd0) begin
            bad++; $display("FAIL async_reset got=valid%b idx%0d val%0d want=all_zero", cell_valid, cell_idx, cell_val);
        end
        cell_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 81; c++) model[c] = '0;
        wb_read(A_PUZ, r, lat);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL reset_clears_cells got=%h want=0", r); end
        wb_read(A_IRQE, r, lat);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL reset_clears_irq_en got=%h want=0", r); end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_stream();
        test_completion();
        test_abort_lockout();
        test_contention();
        test_fail_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sudoku_wb_loader.md
# sudoku_wb_loader

Wishbone-facing front end of the sudoku accelerator, sitting directly behind the Caravel management Wishbone port inside the accelerator wrapper. It holds an 81-cell puzzle buffer written and read by firmware. On command it streams the cells to the solver core over a valid/ready interface and accepts solved cells back into the same buffer. It raises an interrupt when the solver reports completion.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: window base; only `wb_adr_i[31:8]` is compared.
- `wb_clk_i`  in  1: sole clock.
- `wb_rst_i`  in  1: reset, asynchronous, active-high.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i`  in  1 each: Wishbone classic control.
- `wb_sel_i`  in  4: byte enables.
- `wb_adr_i`  in  32: byte address.
- `wb_dat_i`  in  32: write data.
- `wb_ack_o`  out  1: transfer acknowledge.
- `wb_dat_o`  out  32: read data.
- `cell_valid_o`  out  1: a cell is offered to the solver.
- `cell_ready_i`  in  1: the solver accepts the offered cell.
- `cell_idx_o`  out  7: index of the offered cell, 0–80.
- `cell_val_o`  out  4: value of the offered cell; 0 means empty.
- `res_valid_i`  in  1: write-back strobe from the solver.
- `res_idx_i`  in  7: index of the cell being written back.
- `res_val_i`  in  4: value of the cell being written back.
- `solver_done_i`  in  1: one-cycle pulse when the solve ends.
- `solver_fail_i`  in  1: sampled together with `solver_done_i`; 1 means the puzzle has no solution.
- `irq_o`  out  1: interrupt, level-sensitive.

## Operation
- Register map, offsets relative to `BASE_ADDR`:
  - 0x00 CTRL: write bit0 = START, bit1 = ABORT. Both self-clear. Reads return 0.
  - 0x04 STATUS: [1:0] state; bit2 DONE (sticky, write-1-to-clear); bit3 FAIL (sticky, cleared together with DONE).
  - 0x08 IRQ_EN: bit0, read/write.
  - 0x40–0x68 PUZZLE word k (k = 0..10): cell 8k+j lives in bits [4j+3:4j]. Word 10 holds only cell 80, in bits [3:0].
  - Any other offset, and all bits of word 10 above [3:0], read as 0. Writes to them are ignored but still acked.
- Byte-lane rule: `wb_sel_i[b]` gates the two cells packed in byte b.
- State machine:
  - IDLE(0) → STREAM(1) on START.
  - STREAM → WAIT(2) after the handshake on cell 80.
  - WAIT → IDLE on `solver_done_i`. On that transition DONE sets, and FAIL is loaded from `solver_fail_i`.
  - ABORT returns any state to IDLE without setting DONE.
  - START is ignored outside IDLE.
- In STREAM, the streaming index starts at 0 and advances on `cell_valid_o & cell_ready_i`. `cell_val_o` shows the stored value for that index.
- Write-back: `res_valid_i` writes `res_val_i` to `res_idx_i` in any state. An index above 80 is dropped.
- Firmware writes to PUZZLE are dropped in STREAM and WAIT (still acked). They are accepted in IDLE.
- Same cycle, same cell, firmware write plus solver write-back: the solver write wins.
- `irq_o` = DONE & IRQ_EN.

## Timing
- Reset values: all outputs 0, every cell 0, state IDLE, DONE = FAIL = IRQ_EN = 0, streaming index 0.
- Wishbone:
  - A request is `wb_cyc_i & wb_stb_i`. `wb_ack_o` is registered and rises exactly one cycle after the request is sampled, for one cycle.
  - After an ack, the next request can be sampled no earlier than the following cycle. Minimum period is 2 cycles per transfer.
  - `wb_dat_o` is valid only while `wb_ack_o` is high and is 0 otherwise.
  - Register writes commit on the ack edge.
- Address miss (`wb_adr_i[31:8]` ≠ `BASE_ADDR[31:8]`): no ack.
- START: write acked at cycle N, so the state is STREAM and `cell_valid_o` = 1 from cycle N+1, with `cell_idx_o` = 0.
- Streaming:
  - With `cell_ready_i` held high, one cell transfers per cycle: 81 cycles, then WAIT.
  - While `cell_valid_o` is high and `cell_ready_i` is low, `cell_idx_o` and `cell_val_o` hold stable.
  - `cell_valid_o` drops in the cycle after the cell-80 transfer.
- ABORT: `cell_valid_o` drops in the cycle after the ABORT ack; the streaming index returns to 0.
- `solver_done_i` outside WAIT is ignored.
- Reset mid-stream: everything returns to reset values immediately (asynchronous), including the puzzle contents.
- DONE set and a firmware W1C in the same cycle: the set wins.

## Structure
- Package `sudoku_pkg`:
  - `NUM_CELLS` = 81.
  - Cell and index widths.
  - The state enum (IDLE, STREAM, WAIT).
  - Register offset constants.
- Sub-module `sudoku_cell_store`:
  - 81×4 register array.
  - Two write ports (bus and solver) with the solver port taking priority.
  - A combinational read port for the streaming index and a word-assembled read port for the bus.
- Top level: Wishbone decode, ack flop, state machine, status and IRQ logic.

## Test plan
- Reset and registers: after reset, read all PUZZLE words and STATUS → all return 0 and `irq_o` = 0. Write 0x1 to IRQ_EN, read back → 0x1.
- Round trip: write 0x8765_4321 to 0x40, then write 0x4 to 0x48 with `wb_sel_i` = 4'b0001. Reads return 0x8765_4321 and 0x0000_0004. Every ack comes one cycle after its request.
- Streaming with backpressure: fill cells i = i mod 10, then START. With `cell_ready_i` toggling every cycle, the bench sees indices 0..80 in order with values i mod 10. It sees no index repeated or skipped, the state reaches WAIT, and `cell_valid_o` falls after index 80.
- Completion: in WAIT, write `res_idx_i` = 5 with `res_val_i` = 9, then pulse `solver_done_i` with `solver_fail_i` = 0 and IRQ_EN = 1. STATUS reads 0x4, `irq_o` = 1, and cell 5 reads 9. Write 0x4 to STATUS → `irq_o` = 0.
- Abort and lockout:
  - ABORT at cell 40 → `cell_valid_o` low on the next cycle, state IDLE, DONE = 0.
  - A PUZZLE write during STREAM is acked and leaves the cell unchanged.
  - A second START while busy is ignored.
- Contention: a firmware write and a solver write-back to cell 0 in the same cycle, in IDLE → the cell holds the solver value.
